// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 write engine; turns toggle-handshaked LSU lcd words into timed EN strobes.
module lcd_ctrl #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 1,
    parameter int EXEC_CYC  = 2000,
    parameter int CLEAR_CYC = 82000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lcd_word,
    output logic        busy,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        lcd_on,
    output logic        lcd_blon
);
    localparam int M0 = SETUP_CYC > PULSE_CYC ? SETUP_CYC : PULSE_CYC;
    localparam int M1 = M0 > HOLD_CYC ? M0 : HOLD_CYC;
    localparam int M2 = M1 > EXEC_CYC ? M1 : EXEC_CYC;
    localparam int MAXC = M2 > CLEAR_CYC ? M2 : CLEAR_CYC;
    localparam int CW = $clog2(MAXC) + 1;
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;
    state_t state;
    logic last_tog;
    logic [CW-1:0] cnt;
    logic pending;
    logic clr;
    logic unused;
    assign pending = lcd_word[12] != last_tog;
    assign busy = (state != IDLE) | pending;
    assign lcd_rw = 1'b0;
    // clear/home (0x01..0x03 to the instruction register) needs the long wait
    assign clr = !lcd_rs && lcd_data[7:2] == 6'd0 && lcd_data[1:0] != 2'd0;
    assign unused = ^{lcd_word[29:13], lcd_word[11:9]};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last_tog <= 1'b0;
            cnt      <= '0;
            lcd_data <= 8'd0;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_on   <= 1'b0;
            lcd_blon <= 1'b0;
        end else begin
            lcd_on   <= lcd_word[31];
            lcd_blon <= lcd_word[30];
            case (state)
                IDLE: if (pending) begin
                    state    <= SETUP;
                    lcd_data <= lcd_word[7:0];
                    lcd_rs   <= lcd_word[8];
                    last_tog <= lcd_word[12];
                    cnt      <= CW'(SETUP_CYC - 1);
                end
                SETUP: if (cnt == '0) begin
                    state  <= PULSE;
                    lcd_en <= 1'b1;
                    cnt    <= CW'(PULSE_CYC - 1);
                end else cnt <= cnt - 1'b1;
                PULSE: if (cnt == '0) begin
                    state  <= HOLD;
                    lcd_en <= 1'b0;
                    cnt    <= CW'(HOLD_CYC - 1);
                end else cnt <= cnt - 1'b1;
                HOLD: if (cnt == '0) begin
                    state <= WAIT;
                    cnt   <= clr ? CW'(CLEAR_CYC - 1) : CW'(EXEC_CYC - 1);
                end else cnt <= cnt - 1'b1;
                WAIT: if (cnt == '0) state <= IDLE;
                      else cnt <= cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed checks of lcd_ctrl strobe timing, queuing, reset and power bits.
module tb_lcd_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic [31:0] lcd_word;
    logic busy, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
    logic [7:0] lcd_data;
    int checks = 0, failures = 0;
    int idx, en_hi, busy_hi, busy_fall;
    int rise_i[$];
    logic [8:0] rise_d[$];
    logic [7:0] d0;
    logic rs0, prev_en;

    lcd_ctrl dut (
        .clk(clk), .rst(rst), .lcd_word(lcd_word), .busy(busy),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_on(lcd_on), .lcd_blon(lcd_blon)
    );

    always #5 clk = ~clk;

    task automatic start_obs();
        idx = 0; en_hi = 0; busy_hi = 0; busy_fall = -1;
        rise_i.delete(); rise_d.delete();
        prev_en = lcd_en;
    endtask

    // sample index k is taken just after clock edge E0+k
    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (idx == 0) begin d0 = lcd_data; rs0 = lcd_rs; end
            if (lcd_en && !prev_en) begin
                rise_i.push_back(idx);
                rise_d.push_back({lcd_rs, lcd_data});
            end
            prev_en = lcd_en;
            en_hi += int'(lcd_en);
            busy_hi += int'(busy);
            if (!busy && busy_fall < 0) busy_fall = idx;
            idx++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; lcd_word = 32'd0;
        #12;
        checks++;
        if ({busy, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b data=%h rs=%b rw=%b en=%b on=%b blon=%b want all 0",
                     busy, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon);
        end
        @(negedge clk) rst = 1'b1;
        start_obs();
        watch(100);
        checks++;
        if (en_hi != 0 || rise_i.size() != 0) begin
            failures++; $display("FAIL reset_idle_en got en_hi=%0d want 0", en_hi);
        end
        checks++;
        if (busy_hi != 0) begin
            failures++; $display("FAIL reset_idle_busy got busy_cycles=%0d want 0", busy_hi);
        end
    endtask

    task automatic test_data_write();
        lcd_word = 32'h0000_1141;
        #1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL data_busy_same_cycle got %b want 1", busy); end
        start_obs();
        watch(2020);
        checks++;
        if (d0 !== 8'h41 || rs0 !== 1'b1) begin
            failures++; $display("FAIL data_at_e0 got data=%h rs=%b want 41 1", d0, rs0);
        end
        checks++;
        if (rise_i.size() != 1 || rise_i[0] != 2) begin
            failures++; $display("FAIL data_en_rise got rises=%0d first=%0d want 1 at 2",
                                 rise_i.size(), rise_i.size() ? rise_i[0] : -1);
        end
        checks++;
        if (en_hi != 12) begin failures++; $display("FAIL data_en_width got %0d want 12", en_hi); end
        checks++;
        if (busy_fall != 2015 || busy_hi != 2015) begin
            failures++; $display("FAIL data_busy_fall got fall=%0d hi=%0d want 2015 2015", busy_fall, busy_hi);
        end
        checks++;
        if (lcd_data !== 8'h41 || lcd_rs !== 1'b1 || lcd_rw !== 1'b0) begin
            failures++; $display("FAIL data_idle_hold got data=%h rs=%b rw=%b want 41 1 0", lcd_data, lcd_rs, lcd_rw);
        end
    endtask

    task automatic test_clear();
        lcd_word = 32'h0000_0001;
        start_obs();
        watch(82020);
        checks++;
        if (rise_i.size() != 1 || rise_i[0] != 2 || en_hi != 12) begin
            failures++; $display("FAIL clear_en got rises=%0d en_hi=%0d want 1 rise at 2, 12 high",
                                 rise_i.size(), en_hi);
        end
        checks++;
        if (rise_d.size() != 1 || rise_d[0] !== 9'h001) begin
            failures++; $display("FAIL clear_bus got %h want 001", rise_d.size() ? rise_d[0] : 9'h1ff);
        end
        checks++;
        if (busy_fall != 82015) begin
            failures++; $display("FAIL clear_busy_fall got %0d want 82015", busy_fall);
        end
    endtask

    task automatic test_queued();
        lcd_word = 32'h0000_1141;
        start_obs();
        watch(100);
        lcd_word = 32'h0000_0038;
        watch(4100);
        checks++;
        if (rise_i.size() != 2 || rise_i[0] != 2 || rise_i[1] != 2018) begin
            failures++; $display("FAIL queued_rises got n=%0d second=%0d want 2 with second at 2018",
                                 rise_i.size(), rise_i.size() > 1 ? rise_i[1] : -1);
        end
        checks++;
        if (rise_d.size() != 2 || rise_d[0] !== 9'h141 || rise_d[1] !== 9'h038) begin
            failures++; $display("FAIL queued_bus got %h %h want 141 038",
                                 rise_d.size() > 0 ? rise_d[0] : 9'h1ff, rise_d.size() > 1 ? rise_d[1] : 9'h1ff);
        end
        checks++;
        if (en_hi != 24) begin failures++; $display("FAIL queued_en_width got %0d want 24", en_hi); end
        checks++;
        if (busy_fall != 4031 || busy_hi != 4031) begin
            failures++; $display("FAIL queued_busy got fall=%0d hi=%0d want 4031 4031", busy_fall, busy_hi);
        end
    endtask

    task automatic test_reset_pulse_and_power();
        lcd_word = 32'h0000_1122;
        start_obs();
        watch(5);
        checks++;
        if (lcd_en !== 1'b1) begin failures++; $display("FAIL midpulse_en got %b want 1", lcd_en); end
        #2 rst = 1'b0; lcd_word = 32'd0;
        #1;
        checks++;
        if (lcd_en !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL async_reset got en=%b busy=%b want 0 0", lcd_en, busy);
        end
        @(negedge clk) rst = 1'b1;
        lcd_word = 32'h0000_1155;
        start_obs();
        watch(5);
        lcd_word = 32'hC000_1155;
        #1;
        checks++;
        if (lcd_on !== 1'b0 || lcd_blon !== 1'b0) begin
            failures++; $display("FAIL power_early got on=%b blon=%b want 0 0", lcd_on, lcd_blon);
        end
        watch(1);
        checks++;
        if (lcd_on !== 1'b1 || lcd_blon !== 1'b1) begin
            failures++; $display("FAIL power_latency got on=%b blon=%b want 1 1", lcd_on, lcd_blon);
        end
        watch(2014);
        checks++;
        if (rise_i.size() != 1 || rise_i[0] != 2 || en_hi != 12 || rise_d[0] !== 9'h155) begin
            failures++; $display("FAIL post_reset_txn got rises=%0d en_hi=%0d want 1 rise at 2 with 155, 12 high",
                                 rise_i.size(), en_hi);
        end
        checks++;
        if (busy_fall != 2015) begin
            failures++; $display("FAIL post_reset_busy got %0d want 2015", busy_fall);
        end
    endtask

    initial begin
        test_reset();
        test_data_write();
        test_clear();
        test_queued();
        test_reset_pulse_and_power();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Hardware HD44780 write engine that consumes the memory-mapped `lcd` output word produced by the processor's load/store unit and turns each software command into a correctly timed LCD bus transaction. It replaces software bit-banging. The CPU posts a byte and an RS flag with a toggle bit, then polls `busy` through an LSU input register. The block drives the board's character-LCD pins directly and is write-only: `lcd_rw` is always 0.

## Interface
- SETUP_CYC, 2: cycles RS/DATA are stable before EN rises (≥40 ns at 50 MHz).
- PULSE_CYC, 12: cycles EN is held high (≥230 ns).
- HOLD_CYC, 1: cycles RS/DATA are held after EN falls.
- EXEC_CYC, 2000: post-strobe wait for ordinary commands and data (40 µs).
- CLEAR_CYC, 82000: post-strobe wait for clear/home, i.e. rs=0 with data 0x01, 0x02 or 0x03 (1.64 ms).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- lcd_word  in  32  LSU `lcd` register:
  - [31] on
  - [30] backlight
  - [12] tog
  - [8] rs
  - [7:0] data
  - other bits are ignored.
- busy  out  1  command pending or in progress; the LSU maps it to a readable bit.
- lcd_data  out  8  LCD data bus.
- lcd_rs  out  1  register select.
- lcd_rw  out  1  constant 0.
- lcd_en  out  1  enable strobe.
- lcd_on  out  1  LCD power.
- lcd_blon  out  1  backlight.

## Operation
- Internal state:
  - `last_tog` flop.
  - Captured `rs`/`data` registers.
  - One down-counter, width `$clog2` of the largest parameter + 1.
  - FSM with states IDLE, SETUP, PULSE, HOLD, WAIT.
- Request: `pending = lcd_word[12] != last_tog`.
- IDLE with pending at a clock edge is an acceptance:
  - capture `data`/`rs` from `lcd_word` at that edge;
  - `last_tog <= lcd_word[12]`;
  - move to SETUP.
- SETUP: `lcd_en`=0, `lcd_data`/`lcd_rs` = captured values, lasts SETUP_CYC cycles, then PULSE.
- PULSE: `lcd_en`=1 for PULSE_CYC cycles, then HOLD.
- HOLD: `lcd_en`=0, data/rs still held, HOLD_CYC cycles, then WAIT.
- WAIT: lasts CLEAR_CYC cycles if the captured command is clear/home (rs=0, data ∈ {0x01,0x02,0x03}), otherwise EXEC_CYC; then IDLE.
- `lcd_data`/`lcd_rs` keep the last captured values in IDLE.
- `busy = (state != IDLE) | pending`, combinational, so a load issued right after the store already sees 1.
- Toggles while not IDLE are not lost: pending stays set and is accepted on the first IDLE edge, using the `lcd_word` contents at that edge.
- An even number of toggles during a busy period nets to no request (documented software rule: wait for `busy`=0).
- `lcd_on`/`lcd_blon` are registered copies of bits [31]/[30], updated every cycle regardless of FSM state.
- `lcd_en` is a registered output, glitch-free.

## Timing
- Reset values: every output is 0; state IDLE; `last_tog`=0; counter 0. `busy` is 0 while `lcd_word`[12]=0.
- Reset asserted mid-transaction: `lcd_en` drops asynchronously, the FSM returns to IDLE, and the command is abandoned.
- Acceptance edge is E0. Then:
  - `lcd_data`/`lcd_rs` are valid from E0.
  - `lcd_en` is high from E0+SETUP_CYC to E0+SETUP_CYC+PULSE_CYC: E0+2..E0+14 at defaults.
  - HOLD ends at E0+15.
  - IDLE at E0+15+EXEC_CYC = E0+2015, or E0+82015 for clear/home.
- `busy` falls at that IDLE edge unless a new request is already pending.
- Back-to-back: the next acceptance occurs at the IDLE-entry edge + 1, so the minimum command period is SETUP+PULSE+HOLD+WAIT+1 cycles.
- `lcd_on`/`lcd_blon` follow `lcd_word` with 1-cycle latency.

## Test plan
- Reset with `lcd_word`=0:
  - all outputs 0, `busy`=0;
  - hold 100 cycles → no `lcd_en` activity.
- Data write `lcd_word`=0x0000_1141 (tog=1, rs=1, data 0x41):
  - `busy`=1 in the same cycle;
  - `lcd_rs`=1, `lcd_data`=0x41 from E0;
  - `lcd_en` high exactly 12 cycles starting at E0+2;
  - `busy`=0 at E0+2015.
- Clear: tog→0, rs=0, data 0x01 → `lcd_en` pulse as above; `busy` deasserts at E0+82015, not at E0+2015.
- Queued command: toggle with 0x38 while a data write is in WAIT → `busy` stays 1 continuously; the second EN pulse carries 0x38 and starts 3 cycles after the first command reaches IDLE.
- Reset pulse during PULSE → `lcd_en` low within the reset cycle, `busy`=0. After release, toggling tog with data 0x55 produces a full normal transaction.
- Power bits: `lcd_word`[31:30]=2'b11 while the FSM is busy → `lcd_on`=`lcd_blon`=1 one cycle later, and the in-flight transaction is unaffected.
